muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative RV32M/RV64M multiply-divide unit for the EX stage of the pipelined core. It replaces the fixed multiply-only unit and executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. While an operation runs it holds the pipeline through `stalled`. Multiply throughput is set by a radix parameter, and division can be compiled out.

## Interface
- `XLEN`, 32, operand/result width; must be 32 or 64.
- `MUL_STEP`, 2, multiplier bits retired per BUSY cycle; one of 1, 2, 4, 8; must divide `XLEN`.

- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `ce` input 1: M-type instruction present in EX. Held high for as long as that instruction stays in EX.
- `kill` input 1: synchronous abort of the in-flight operation (EX flush).
- `funct3` input 3: RV32M operation encoding, 000 MUL through 111 REMU.
- `a` input `XLEN`: rs1 operand (forwarded SrcA).
- `b` input `XLEN`: rs2 operand (forwarded SrcB).
- `result` output `XLEN`: operation result, valid when `done`=1.
- `stalled` output 1: pipeline hold request to the ID/EX and EX/MEM enables and to the hazard unit.
- `done` output 1: single-cycle result-valid strobe.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE, `ce`=1, normal case:**
  - Latch operand magnitudes, result sign and op class.
  - Load step counter with N, where N = `XLEN`/`MUL_STEP` for multiply and N = `XLEN` for divide.
  - Go to BUSY.
  - `stalled`=1 combinationally in this same cycle.
- **IDLE, `ce`=1, special case (division only):** no state change, `stalled`=0, `done`=1, `result` driven combinationally.
  - Divisor zero: DIV/DIVU → all ones; REM/REMU → `a`.
  - Signed overflow (`a` = most-negative, `b` = −1): DIV → `a`; REM → 0.
- **BUSY:** `stalled`=1.
  - Multiply: shift-add of `MUL_STEP` bits per cycle into a 2·`XLEN` accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - When the counter reaches 0, apply sign correction into the result register and go to DONE.
- **DONE:** `stalled`=0, `done`=1, `result` = result register. Next state is IDLE unconditionally.
  - Unconditional return to IDLE means the same instruction, still in EX this cycle, cannot re-trigger.
- **Result selection:**
  - MUL = low `XLEN` bits.
  - MULH/MULHSU/MULHU = high `XLEN` bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
  - DIV/DIVU = quotient, truncated toward zero.
  - REM/REMU = remainder, which takes the sign of the dividend.
- **`kill`=1 in any state:** next state IDLE, result register unchanged, `done`=0 that cycle.
  - `stalled` follows the current state; `kill` has priority over `ce`.
- `ce`=0 while in BUSY does not abort the operation; only `kill` and `reset` abort.

## Timing
- **Reset values:** state IDLE, `result`=0, `stalled`=0, `done`=0, counter 0.
- Reset mid-operation aborts to IDLE on the next edge.
- Stall length: N+1 cycles.
  - Multiply: `XLEN`/`MUL_STEP`+1, i.e. 17 at the defaults.
  - Divide: `XLEN`+1, i.e. 33 for RV32.
- Sequence: IDLE cycle and all BUSY cycles hold `stalled`=1; the result appears in the DONE cycle with `stalled`=0, and EX/MEM captures it on that edge.
- Special-case division: 0 stall cycles.
- Back-to-back M instructions: the second one sees IDLE on the cycle after DONE and starts with no bubble beyond its own latency.
- Operands are sampled only in the IDLE start cycle; later changes on `a`/`b` are ignored.
- `funct3` values outside the enabled set: `result`=0, `done`=1, `stalled`=0.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath, division special cases and funct3 100–111 are all implemented.
- Not defined: no divider logic is synthesised.
  - funct3 100–111 with `ce`=1 produce `result`=0 and `done`=1 in the IDLE cycle, `stalled`=0.
  - Multiply behaviour is identical in both builds.

## Test plan
- MUL, `a`=7, `b`=0xFFFFFFFD (−3), defaults → `stalled` high 17 cycles, then `result`=0xFFFFFFEB with `done`=1 for one cycle.
- MULH `a`=`b`=0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, each after 33 stall cycles. DIVU x/0 → 0xFFFFFFFF and REM 5/0 → 5, both with `stalled` never asserted.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0; both zero-latency.
- `kill` in the 5th BUSY cycle → IDLE the next cycle, `done` never pulses. A fresh MUL 3×4 then returns 12 after the full latency.
- Two consecutive MULs with `ce` held high (6×7, then 2×3) → `done` pulses exactly twice with results 42 and 6. `reset` asserted mid-BUSY → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2^MUL_STEP shift-add multiplier, restoring divider.
// Define MULDIV_DIV_EN to build the divider; without it funct3 1xx completes at once with result 0.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            stalled,
  output logic            done
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_CYCLES = CW'(XLEN / MUL_STEP);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                sa_en, sb_en;
  logic [XLEN-1:0]     op_a, op_b;
  logic                a_neg, b_neg;

  // Which operands are treated as signed for the incoming funct3
  always_comb begin
    sa_en = 1'b0;
    sb_en = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin
        sa_en = 1'b1;
        sb_en = 1'b1;
      end
      3'b010:  sa_en = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = sa_en & a[XLEN-1];
  assign b_neg = sb_en & b[XLEN-1];
  assign op_a  = a_neg ? -a : a;
  assign op_b  = b_neg ? -b : b;

  // Multiply step: acc = {running high half, unconsumed multiplier bits}
  logic [XLEN+MUL_STEP-1:0]   pp [MUL_STEP];
  logic [XLEN+MUL_STEP-1:0]   mul_sum;
  logic [2*XLEN+MUL_STEP-1:0] mul_wide;
  logic [2*XLEN-1:0]          mul_next, mul_prod;
  logic [XLEN-1:0]            mul_res;

  for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
    assign pp[gi] = acc_q[gi] ? ({{MUL_STEP{1'b0}}, opnd_q} << gi) : '0;
  end

  always_comb begin
    mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    for (int i = 0; i < MUL_STEP; i++) begin
      mul_sum = mul_sum + pp[i];
    end
  end

  assign mul_wide = {mul_sum, acc_q[XLEN-1:0]};
  assign mul_next = mul_wide[2*XLEN+MUL_STEP-1:MUL_STEP];
  assign mul_prod = neg_q ? -mul_next : mul_next;
  assign mul_res  = (op_q == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  logic [2*XLEN-1:0] step_next;
  logic [XLEN-1:0]   fin_res;

`ifdef MULDIV_DIV_EN
  localparam logic [CW-1:0]   DIV_CYCLES = CW'(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}
  logic [XLEN:0]     rem_shift, rem_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_val, div_res;
  logic              div_zero, div_ovf;

  assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};
  assign div_next  = rem_diff[XLEN] ? {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign div_val   = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
  assign div_res   = neg_q ? -div_val : div_val;

  assign div_zero  = (b == '0);
  assign div_ovf   = !funct3[0] && (a == MOST_NEG) && (b == '1);

  assign step_next = op_q[2] ? div_next : mul_next;
  assign fin_res   = op_q[2] ? div_res : mul_res;
`else
  assign step_next = mul_next;
  assign fin_res   = mul_res;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    stalled  = 1'b0;
    done     = 1'b0;
    result   = result_q;

    case (state_q)
      IDLE: begin
        if (ce && !kill) begin
          if (funct3[2]) begin
`ifdef MULDIV_DIV_EN
            if (div_zero) begin
              done   = 1'b1;
              result = funct3[1] ? a : '1;
            end else if (div_ovf) begin
              done   = 1'b1;
              result = funct3[1] ? '0 : a;
            end else begin
              stalled = 1'b1;
              opnd_d  = op_b;
              acc_d   = {{XLEN{1'b0}}, op_a};
              // Remainder follows the dividend sign only
              neg_d   = funct3[1] ? a_neg : (a_neg ^ b_neg);
              cnt_d   = DIV_CYCLES;
              op_d    = funct3;
              state_d = BUSY;
            end
`else
            done   = 1'b1;
            result = '0;
`endif
          end else begin
            stalled = 1'b1;
            opnd_d  = op_b;
            acc_d   = {{XLEN{1'b0}}, op_a};
            neg_d   = a_neg ^ b_neg;
            cnt_d   = MUL_CYCLES;
            op_d    = funct3;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        stalled = 1'b1;
        if (kill) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = fin_res;
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        // Always fall back to IDLE so the same instruction cannot re-trigger
        done    = !kill;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32, MUL_STEP=2 (either MULDIV_DIV_EN build).
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        stalled;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_STEP(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .kill   (kill),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .result (result),
    .stalled(stalled),
    .done   (done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // Issues one op with ce held until done; scrambles a/b after the start cycle. Measures only.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int stalls, output logic got);
    res    = '0;
    stalls = 0;
    got    = 1'b0;
    funct3 = f;
    a      = x;
    b      = y;
    ce     = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stalled) stalls++;
      if (done) begin
        res = result;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (got) break;
      a = ~x;
      b = y ^ 32'h00FF_0F0F;
    end
    ce = 1'b0;
    $display("op funct3=%b a=%h b=%h -> result=%h stalls=%0d done_seen=%0b", f, x, y, res, stalls, got);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b0;
    kill  = 1'b0;
    funct3 = 3'b000;
    a = '0;
    b = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected %h", result, 32'h0); end
    checks++;
    if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled got %b expected 0", stalled); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_mul();
    logic [2:0]  vf [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b001, 3'b000, 3'b011, 3'b010};
    logic [31:0] vx [8] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFD, 32'h1234_5678, 32'h8000_0000, 32'd2};
    logic [31:0] vy [8] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                            32'd5, 32'h10, 32'd4, 32'hFFFF_FFFF};
    logic [31:0] ve [8] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'h2345_6780, 32'd2, 32'd1};
    logic [31:0] res;
    int          stalls;
    logic        got;
    for (int i = 0; i < 8; i++) begin
      run_op(vf[i], vx[i], vy[i], res, stalls, got);
      checks++;
      if (got !== 1'b1) begin errors++; $display("FAIL mul_done[%0d] got %b expected 1", i, got); end
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL mul_result[%0d] got %h expected %h", i, res, ve[i]); end
      checks++;
      if (stalls != 17) begin errors++; $display("FAIL mul_stalls[%0d] got %0d expected 17", i, stalls); end
      if (i == 0) begin
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mul_done_width got %b expected 0", done); end
      end
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    logic [2:0]  vf [8] = '{3'b100, 3'b110, 3'b101, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] vx [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd5,
                            32'h8000_0000, 32'h8000_0000, 32'd100, 32'd100};
    logic [31:0] vy [8] = '{32'd2, 32'd2, 32'd0, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7};
    logic [31:0] ve [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                            32'h8000_0000, 32'd0, 32'd14, 32'd2};
    int          vs [8] = '{33, 33, 0, 0, 0, 0, 33, 33};
    logic [31:0] res;
    int          stalls;
    logic        got;
    for (int i = 0; i < 8; i++) begin
      run_op(vf[i], vx[i], vy[i], res, stalls, got);
      checks++;
      if (got !== 1'b1) begin errors++; $display("FAIL div_done[%0d] got %b expected 1", i, got); end
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL div_result[%0d] got %h expected %h", i, res, ve[i]); end
      checks++;
      if (stalls != vs[i]) begin errors++; $display("FAIL div_stalls[%0d] got %0d expected %0d", i, stalls, vs[i]); end
    end
  endtask
`else
  task automatic test_div_disabled();
    logic [31:0] res;
    int          stalls;
    logic        got;
    for (int i = 4; i < 8; i++) begin
      run_op(3'(i), 32'd100, 32'd7, res, stalls, got);
      checks++;
      if (got !== 1'b1) begin errors++; $display("FAIL nodiv_done[%0d] got %b expected 1", i, got); end
      checks++;
      if (res !== 32'd0) begin errors++; $display("FAIL nodiv_result[%0d] got %h expected 0", i, res); end
      checks++;
      if (stalls != 0) begin errors++; $display("FAIL nodiv_stalls[%0d] got %0d expected 0", i, stalls); end
    end
  endtask
`endif

  task automatic test_kill();
    logic [31:0] res;
    int          stalls;
    logic        got;
    int          dones;
    run_op(3'b000, 32'd5, 32'd5, res, stalls, got);
    checks++;
    if (res !== 32'd25) begin errors++; $display("FAIL kill_pre_result got %h expected %h", res, 32'd25); end
    funct3 = 3'b000;
    a  = 32'h1234;
    b  = 32'h55;
    ce = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
    end
    kill = 1'b1;
    #1;
    checks++;
    if (stalled !== 1'b1) begin errors++; $display("FAIL kill_cycle_stalled got %b expected 1", stalled); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL kill_cycle_done got %b expected 0", done); end
    @(posedge clk);
    #1;
    kill = 1'b0;
    ce   = 1'b0;
    #1;
    checks++;
    if (stalled !== 1'b0) begin errors++; $display("FAIL kill_next_stalled got %b expected 0", stalled); end
    checks++;
    if (result !== 32'd25) begin errors++; $display("FAIL kill_result_kept got %h expected %h", result, 32'd25); end
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL kill_no_done got %0d pulses expected 0", dones); end
    $display("kill issued in 5th busy cycle, done pulses afterwards=%0d", dones);
    run_op(3'b000, 32'd3, 32'd4, res, stalls, got);
    checks++;
    if (res !== 32'd12) begin errors++; $display("FAIL kill_fresh_result got %h expected %h", res, 32'd12); end
    checks++;
    if (stalls != 17) begin errors++; $display("FAIL kill_fresh_stalls got %0d expected 17", stalls); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res [2];
    int          cyc [2];
    int          n;
    res[0] = '0;
    res[1] = '0;
    cyc[0] = -1;
    cyc[1] = -1;
    n = 0;
    funct3 = 3'b000;
    a  = 32'd6;
    b  = 32'd7;
    ce = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (done) begin
        if (n < 2) begin
          res[n] = result;
          cyc[n] = c;
        end
        n++;
        $display("back_to_back done at cycle %0d result=%h", c, result);
      end
      @(posedge clk);
      #1;
      if (n == 1 && a == 32'd6) begin
        a = 32'd2;
        b = 32'd3;
      end
      if (n >= 2) ce = 1'b0;
    end
    ce = 1'b0;
    checks++;
    if (n != 2) begin errors++; $display("FAIL b2b_pulses got %0d expected 2", n); end
    checks++;
    if (res[0] !== 32'd42) begin errors++; $display("FAIL b2b_first got %h expected %h", res[0], 32'd42); end
    checks++;
    if (res[1] !== 32'd6) begin errors++; $display("FAIL b2b_second got %h expected %h", res[1], 32'd6); end
    checks++;
    if (cyc[0] != 17) begin errors++; $display("FAIL b2b_first_cycle got %0d expected 17", cyc[0]); end
    checks++;
    if (cyc[1] != 35) begin errors++; $display("FAIL b2b_second_cycle got %0d expected 35", cyc[1]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          stalls;
    logic        got;
    run_op(3'b000, 32'd6, 32'd7, res, stalls, got);
    checks++;
    if (res !== 32'd42) begin errors++; $display("FAIL rst_pre_result got %h expected %h", res, 32'd42); end
    funct3 = 3'b000;
    a  = 32'd9;
    b  = 32'd9;
    ce = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (stalled !== 1'b1) begin errors++; $display("FAIL rst_busy_stalled got %b expected 1", stalled); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ce    = 1'b0;
    #1;
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h expected 0", result); end
    checks++;
    if (stalled !== 1'b0) begin errors++; $display("FAIL rst_mid_stalled got %b expected 0", stalled); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b expected 0", done); end
    $display("reset asserted mid-busy, outputs result=%h stalled=%b done=%b", result, stalled, done);
  endtask

  initial begin
    test_reset();
    test_mul();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
